// File: rtl/traffic_phase_timer.sv
// Traffic phase timer.
// Times one green/yellow phase for the light the sequencer selects, then
// pulses counter_done. A light is served once per entry; selecting a
// different light (or an invalid selection) mid-phase aborts the phase.
//
// Ports:
//   clk            system clock, all state on rising edge
//   rst            synchronous active-high reset
//   tick_1s        one-cycle 1 Hz enable pulse
//   short_counter  short green-time request
//   long_counter   long green-time request, wins over short_counter
//   current_state  one-hot active light from the sequencer (bit0 = light 1)
//   counter_done   one-cycle pulse at phase completion
//   o_light_1..4   lamp codes: 001 RED, 010 YELLOW, 100 GREEN
//   o_sec_left     seconds left in the GREEN or YELLOW interval, else 0
module traffic_phase_timer #(
    parameter int unsigned SHORT_SEC  = 10,
    parameter int unsigned LONG_SEC   = 60,
    parameter int unsigned YELLOW_SEC = 3,
    localparam int unsigned MAX_GY  = (SHORT_SEC > LONG_SEC) ? SHORT_SEC : LONG_SEC,
    localparam int unsigned MAX_SEC = (MAX_GY > YELLOW_SEC) ? MAX_GY : YELLOW_SEC,
    localparam int unsigned CW      = $clog2(MAX_SEC + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_1s,
    input  logic          short_counter,
    input  logic          long_counter,
    input  logic [3:0]    current_state,
    output logic          counter_done,
    output logic [2:0]    o_light_1,
    output logic [2:0]    o_light_2,
    output logic [2:0]    o_light_3,
    output logic [2:0]    o_light_4,
    output logic [CW-1:0] o_sec_left
);

    localparam logic [2:0] LAMP_RED    = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b100;

    typedef enum logic [1:0] {
        StIdle,
        StGreen,
        StYellow,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [3:0]       served_q, served_d;
    logic [3:0][2:0]  lamp_q, lamp_d;
    logic             cs_onehot;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        served_d  = served_q;
        cs_onehot = (current_state != 4'd0) &&
                    ((current_state & (current_state - 4'd1)) == 4'd0);

        unique case (state_q)
            StIdle: begin
                // A new valid selection is always recorded as served, even with
                // no request, so a request-less light counts as a zero-time phase.
                if (cs_onehot && (current_state != served_q)) begin
                    served_d = current_state;
                    if (long_counter) begin
                        state_d = StGreen;
                        count_d = CW'(LONG_SEC);
                    end else if (short_counter) begin
                        state_d = StGreen;
                        count_d = CW'(SHORT_SEC);
                    end
                end
            end
            StGreen, StYellow: begin
                // served_q is one-hot here, so any mismatch also catches an
                // invalid (non-one-hot) selection.
                if (current_state != served_q) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (tick_1s) begin
                    if (count_q == CW'(1)) begin
                        if (state_q == StGreen) begin
                            state_d = StYellow;
                            count_d = CW'(YELLOW_SEC);
                        end else begin
                            state_d = StDone;
                            count_d = '0;
                        end
                    end else if (count_q != '0) begin
                        count_d = count_q - CW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
    end

    // Lamps are registered from the next state so they line up with state_q.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lamp_d[i] = LAMP_RED;
            if (served_d[i]) begin
                if (state_d == StGreen) begin
                    lamp_d[i] = LAMP_GREEN;
                end else if (state_d == StYellow) begin
                    lamp_d[i] = LAMP_YELLOW;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            served_q <= 4'b0000;
            lamp_q   <= {4{LAMP_RED}};
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            served_q <= served_d;
            lamp_q   <= lamp_d;
        end
    end

    always_comb begin
        counter_done = (state_q == StDone);
        o_sec_left   = ((state_q == StGreen) || (state_q == StYellow)) ? count_q : '0;
        o_light_1    = lamp_q[0];
        o_light_2    = lamp_q[1];
        o_light_3    = lamp_q[2];
        o_light_4    = lamp_q[3];
    end

endmodule
